fork_join_ctrl: RTL and testbench
=================================

Name: fork_join_ctrl

Overview:
Hardware join collector for a fork/join dispatcher. It accepts one fork command carrying a join mode (JOIN, JOIN_ANY or JOIN_NONE) and raises one request per branch toward external worker engines. It collects the branch completion pulses and emits a single continuation pulse when the mode's join condition is met. It reports the fork-to-join latency in cycles and blocks the next fork until every branch has drained.

Parameters:
N_BR, 2, number of parallel branches (1..8)
CW, 16, width of the elapsed-cycle counter and of join_time

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  synchronous active-low reset
fork_valid  in  1  fork command valid
fork_ready  out  1  controller can accept a fork
fork_mode  in  2  00 JOIN, 01 JOIN_ANY, 10 JOIN_NONE, 11 reserved (treated as JOIN)
br_req  out  N_BR  per-branch run request; level, held until that branch completes
br_done  in  N_BR  per-branch completion; single-cycle pulse
join_pulse  out  1  continuation release; one cycle, exactly once per fork
join_time  out  CW  cycles from fork accept to join_pulse; held until the next join
busy  out  1  one or more branches outstanding
err  out  1  sticky: br_done arrived on a branch that was not pending

Behaviour:
- Reset (rst_n low at a clk edge):
  - All of the following are 0: pending, state, br_req, join_pulse, join_time, busy, err, elapsed.
  - fork_ready is 1 from the first cycle after reset.
  - Reset mid-operation drops all requests and emits no join_pulse.
- Accept: handshake fork_valid && fork_ready completes at edge T.
  - Mode is latched and pending is set to all ones.
  - br_req equals pending, so it is high from cycle T+1.
  - elapsed = 0 in cycle T+1 and increments by 1 each cycle, saturating at 2^CW-1.
- FSM states: IDLE, WAIT_JOIN, DRAIN.
  - IDLE: fork_ready = 1.
    - Accept with JOIN or JOIN_ANY moves to WAIT_JOIN.
    - Accept with JOIN_NONE moves to DRAIN and asserts join_pulse in T+1 with join_time = 0.
  - WAIT_JOIN: br_done[i] sampled at edge D clears pending[i] at D+1.
    - JOIN: join_pulse in the cycle after the edge at which pending reaches 0; then go to IDLE.
    - JOIN_ANY: join_pulse in the cycle after the first sampled br_done; then go to DRAIN (or IDLE if pending is already 0).
    - join_time is loaded with elapsed in the join_pulse cycle. A done sampled k edges after accept gives join_time = k.
  - DRAIN: no further join_pulse. Go to IDLE in the cycle after pending reaches 0.
- fork_ready = (state == IDLE). A fork is never accepted while any branch is pending.
- busy = |pending.
- Simultaneous dones:
  - JOIN_ANY: multiple dones in one cycle produce a single join_pulse.
  - JOIN: the last done(s), together or staggered, produce one join_pulse.
- br_done[i] while pending[i] = 0 is ignored for join purposes and sets err.
- N_BR = 1: all three modes degenerate correctly; JOIN and JOIN_ANY are identical.
- Back-to-back forks: the minimum gap is one IDLE cycle after the join/drain completes.
- join_pulse is registered; there is no combinational path from br_done to join_pulse.

Decomposition:
- Package fork_join_pkg:
  - mode_e enum {JOIN = 2'b00, JOIN_ANY = 2'b01, JOIN_NONE = 2'b10}
  - state_e enum {IDLE, WAIT_JOIN, DRAIN}
  - mode decode function that maps 11 to JOIN
- Sub-module fj_sat_counter: clear, enable and saturating CW-bit counter used for elapsed. The rest stays flat in fork_join_ctrl.

Test Plan:
- JOIN, N_BR=2, done[0] 10 edges and done[1] 20 edges after accept -> one join_pulse with join_time = 20; br_req[0] drops 11 cycles after accept, br_req[1] 21 cycles after accept; fork_ready returns the cycle after the pulse.
- JOIN_ANY, same timing -> join_pulse with join_time = 10; busy stays high until br_req[1] drops; fork_ready low until then.
- JOIN_NONE, dones at 10 and 20 -> join_pulse in T+1 with join_time = 0; no further pulses; IDLE after done[1].
- JOIN_ANY with done[0] and done[1] both at 15 -> exactly one join_pulse, join_time = 15, then straight to IDLE.
- Spurious done[1] in IDLE, then rst_n low during WAIT_JOIN -> err = 1 after the spurious pulse; reset clears err, br_req and busy, with no join_pulse.
- fork_mode = 11 with dones at 5 and 7 -> behaves as JOIN, join_time = 7; a second fork_valid held during WAIT_JOIN is not accepted until IDLE.

Source files
------------

// File: rtl/fork_join_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fork_join_pkg
// Description : Shared types and the fork-mode decode used by the fork/join
//               join collector.
// Revision    : 1.0 - initial release
// ============================================================================
package fork_join_pkg;

    typedef enum logic [1:0] {
        JOIN      = 2'b00,
        JOIN_ANY  = 2'b01,
        JOIN_NONE = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_JOIN = 2'd1,
        DRAIN     = 2'd2
    } state_e;

    // The reserved encoding 2'b11 behaves exactly like a full JOIN.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b01:   m = JOIN_ANY;
            2'b10:   m = JOIN_NONE;
            default: m = JOIN;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fj_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : fj_sat_counter
// Description : Clearable, enabled up-counter that sticks at its maximum.
// Revision    : 1.0 - initial release
// ============================================================================
module fj_sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear has priority; otherwise count up while enabled, holding at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fork_join_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fork_join_ctrl
// Description : Join collector for a fork/join dispatcher. Raises one request
//               per branch, gathers completions and releases a single
//               registered continuation pulse according to the join mode.
// Revision    : 1.0 - initial release
// ============================================================================
module fork_join_ctrl
    import fork_join_pkg::*;
#(
    parameter int N_BR = 2,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fork_valid,
    output logic            fork_ready,
    input  logic [1:0]      fork_mode,
    output logic [N_BR-1:0] br_req,
    input  logic [N_BR-1:0] br_done,
    output logic            join_pulse,
    output logic [CW-1:0]   join_time,
    output logic            busy,
    output logic            err
);

    state_e          state_q,      state_d;
    mode_e           mode_q,       mode_d;
    logic [N_BR-1:0] pending_q,    pending_d;
    logic            join_pulse_q, join_pulse_d;
    logic [CW-1:0]   join_time_q,  join_time_d;
    logic            err_q,        err_d;

    logic            accept;
    logic [N_BR-1:0] hits;
    logic [CW-1:0]   elapsed;
    logic [CW-1:0]   elapsed_next;

    assign accept = fork_valid && (state_q == IDLE);
    assign hits   = br_done & pending_q;

    // The pulse is registered, so its join_time must be the elapsed value of
    // the pulse cycle, i.e. the counter's next value (saturating).
    assign elapsed_next = (elapsed == {CW{1'b1}}) ? elapsed
                                                  : elapsed + {{(CW-1){1'b0}}, 1'b1};

    fj_sat_counter #(
        .CW (CW)
    ) u_elapsed (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_q != IDLE),
        .cnt   (elapsed)
    );

    // Next-state logic: branch bookkeeping, join decision and error capture.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        pending_d    = pending_q & ~br_done;
        join_pulse_d = 1'b0;
        join_time_d  = join_time_q;
        err_d        = err_q | (|(br_done & ~pending_q));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d    = decode_mode(fork_mode);
                    pending_d = {N_BR{1'b1}};
                    if (decode_mode(fork_mode) == JOIN_NONE) begin
                        state_d      = DRAIN;
                        join_pulse_d = 1'b1;
                        join_time_d  = '0;
                    end else begin
                        state_d = WAIT_JOIN;
                    end
                end
            end
            WAIT_JOIN: begin
                // Leave one cycle after everything has drained, so the join
                // cycle itself is never also an accept cycle.
                if (pending_q == '0) begin
                    state_d = IDLE;
                end else if (mode_q == JOIN_ANY) begin
                    if (|hits) begin
                        join_pulse_d = 1'b1;
                        join_time_d  = elapsed_next;
                        if (pending_d != '0) begin
                            state_d = DRAIN;
                        end
                    end
                end else if (pending_d == '0) begin
                    join_pulse_d = 1'b1;
                    join_time_d  = elapsed_next;
                end
            end
            DRAIN: begin
                if (pending_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= JOIN;
            pending_q    <= '0;
            join_pulse_q <= 1'b0;
            join_time_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            join_pulse_q <= join_pulse_d;
            join_time_q  <= join_time_d;
            err_q        <= err_d;
        end
    end

    assign fork_ready = (state_q == IDLE);
    assign br_req     = pending_q;
    assign busy       = |pending_q;
    assign join_pulse = join_pulse_q;
    assign join_time  = join_time_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fork_join_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fork_join_ctrl
// Description : Directed self-checking bench for fork_join_ctrl (N_BR=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fork_join_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fork_valid;
    logic        fork_ready;
    logic [1:0]  fork_mode;
    logic [1:0]  br_req;
    logic [1:0]  br_done;
    logic        join_pulse;
    logic [15:0] join_time;
    logic        busy;
    logic        err;

    int checks;
    int errors;

    // Per-fork observations; cycle numbers count from 1 = first cycle after accept.
    int pulses, pulse_c, jt, drop0, drop1, busy_c, ready_c, rearm_c;

    fork_join_ctrl #(
        .N_BR (2),
        .CW   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fork_valid (fork_valid),
        .fork_ready (fork_ready),
        .fork_mode  (fork_mode),
        .br_req     (br_req),
        .br_done    (br_done),
        .join_pulse (join_pulse),
        .join_time  (join_time),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one fork, then run ncyc cycles, pulsing done[i] so that it is
    // sampled d_i edges after the accept edge, and record what happens.
    task automatic run_fork(input logic [1:0] m, input int d0, input int d1,
                            input int ncyc, input bit hold);
        pulses = 0; pulse_c = -1; jt = -1; drop0 = -1; drop1 = -1;
        busy_c = -1; ready_c = -1; rearm_c = -1;
        fork_valid = 1'b1;
        fork_mode  = m;
        tick();
        if (!hold) fork_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (join_pulse) begin
                pulses++;
                pulse_c = c;
                jt      = int'(join_time);
            end
            if (drop0 < 0 && !br_req[0]) drop0 = c;
            if (drop1 < 0 && !br_req[1]) drop1 = c;
            if (busy_c < 0 && !busy) busy_c = c;
            if (ready_c >= 0 && rearm_c < 0 && br_req == 2'b11) rearm_c = c;
            if (ready_c < 0 && fork_ready) ready_c = c;
            br_done = {(c == d1), (c == d0)};
            tick();
        end
        br_done    = 2'b00;
        fork_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        fork_valid = 1'b0;
        fork_mode  = 2'b00;
        br_done    = 2'b00;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check_eq("rst_ready", fork_ready, 1);
        check_eq("rst_req",   br_req, 0);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_pulse", join_pulse, 0);
        check_eq("rst_jtime", join_time, 0);
        check_eq("rst_err",   err, 0);

        // JOIN, dones at 10 and 20
        run_fork(2'b00, 10, 20, 25, 1'b0);
        check_eq("join_pulses", pulses, 1);
        check_eq("join_pulse_c", pulse_c, 21);
        check_eq("join_time", jt, 20);
        check_eq("join_drop0", drop0, 11);
        check_eq("join_drop1", drop1, 21);
        check_eq("join_ready", ready_c, 22);
        check_eq("join_jt_held", join_time, 20);

        // JOIN_ANY, dones at 10 and 20
        run_fork(2'b01, 10, 20, 25, 1'b0);
        check_eq("any_pulses", pulses, 1);
        check_eq("any_pulse_c", pulse_c, 11);
        check_eq("any_time", jt, 10);
        check_eq("any_busy_drop", busy_c, 21);
        check_eq("any_drop1", drop1, 21);
        check_eq("any_ready", ready_c, 22);

        // JOIN_NONE, dones at 10 and 20
        run_fork(2'b10, 10, 20, 25, 1'b0);
        check_eq("none_pulses", pulses, 1);
        check_eq("none_pulse_c", pulse_c, 1);
        check_eq("none_time", jt, 0);
        check_eq("none_ready", ready_c, 22);

        // JOIN_ANY, both dones at 15
        run_fork(2'b01, 15, 15, 20, 1'b0);
        check_eq("any2_pulses", pulses, 1);
        check_eq("any2_pulse_c", pulse_c, 16);
        check_eq("any2_time", jt, 15);
        check_eq("any2_drop", drop0, 16);
        check_eq("any2_ready", ready_c, 17);

        // Reserved mode with fork_valid held throughout
        run_fork(2'b11, 5, 7, 12, 1'b1);
        check_eq("rsv_pulses", pulses, 1);
        check_eq("rsv_pulse_c", pulse_c, 8);
        check_eq("rsv_time", jt, 7);
        check_eq("rsv_drop0", drop0, 6);
        check_eq("rsv_ready", ready_c, 9);
        check_eq("rsv_rearm", rearm_c, 10);
        check_eq("rsv_err", err, 0);
        // Finish off the fork accepted at the end of the held-valid run.
        br_done = 2'b11;
        tick();
        br_done = 2'b00;
        check_eq("rsv2_pulse", join_pulse, 1);
        tick();
        check_eq("rsv2_ready", fork_ready, 1);

        // Spurious done in IDLE sets a sticky error
        br_done = 2'b10;
        tick();
        br_done = 2'b00;
        check_eq("spur_err", err, 1);
        tick();
        check_eq("spur_err_sticky", err, 1);

        // Reset in the middle of WAIT_JOIN
        fork_valid = 1'b1;
        fork_mode  = 2'b00;
        tick();
        fork_valid = 1'b0;
        tick(); tick();
        check_eq("mid_req", br_req, 3);
        check_eq("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check_eq("mrst_req", br_req, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_err", err, 0);
        check_eq("mrst_pulse", join_pulse, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("mrst_ready", fork_ready, 1);
        check_eq("mrst_pulse2", join_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
